instr_mem_fetch: RTL and testbench

Parametrised, handshaked instruction memory that succeeds the single-cycle combinational-read instruction RAM. It sits between the fetch stage and the boot/loader path of the RISC-V pipeline. Fetches are registered: one response per cycle, with back-pressure, flush and range/alignment fault reporting. A byte-enable loader port writes instructions into the store.

---
 rtl/instr_mem_pkg.sv | 31 +++
 rtl/instr_mem_array.sv | 35 +++
 rtl/instr_mem_fetch.sv | 104 ++++++++++
 tb/tb_instr_mem_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and address decode for the registered instruction memory.
package instr_mem_pkg;

    localparam logic [31:0] RV_NOP          = 32'h0000_0013;
    localparam logic [31:0] DEF_SEG_BASE    = 32'h0000_2000;
    localparam int unsigned DEF_DEPTH_WORDS = 2048;

    typedef struct packed {
        logic [63:0] index;
        logic        in_range;
    } word_loc_t;

    // Offset is wrapped to addr_w bits so an address below base underflows to a huge index.
    function automatic word_loc_t word_loc(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned addr_w,
        input int unsigned depth,
        input int unsigned off_w
    );
        word_loc_t   r;
        logic [63:0] mask;
        logic [63:0] diff;
        mask       = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
        diff       = (addr - base) & mask;
        r.index    = diff >> off_w;
        r.in_range = (r.index < 64'(depth));
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Block-RAM style word store: synchronous read with enable, byte-enable write, no reset.
module instr_mem_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned IDX_W       = 11
) (
    input  logic                  clk,
    input  logic                  i_rd_en,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_W-1:0]     o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int unsigned b = 0; b < DATA_W/8; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_fetch.sv
// Handshaked instruction memory: registered fetch responses with flush and fault
// reporting, plus a byte-enable loader port that takes priority over fetches.
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int unsigned     ADDR_W      = 32,
    parameter int unsigned     DATA_W      = 32,
    parameter int unsigned     DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter logic [ADDR_W-1:0] SEG_BASE  = ADDR_W'(DEF_SEG_BASE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req_valid_i,
    output logic                fetch_req_ready_o,
    input  logic [ADDR_W-1:0]   fetch_addr_i,
    input  logic                fetch_flush_i,
    output logic                fetch_resp_valid_o,
    input  logic                fetch_resp_ready_i,
    output logic [DATA_W-1:0]   fetch_instr_o,
    output logic                fetch_fault_o,
    input  logic                load_wr_en_i,
    input  logic [ADDR_W-1:0]   load_addr_i,
    input  logic [DATA_W-1:0]   load_data_i,
    input  logic [DATA_W/8-1:0] load_be_i,
    output logic                load_err_o
);

    localparam int unsigned       BYTES    = DATA_W / 8;
    localparam int unsigned       OFF_W    = $clog2(BYTES);
    localparam int unsigned       IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(RV_NOP);

    word_loc_t         w_fetch_loc;
    word_loc_t         w_load_loc;
    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_load_idx;
    logic              w_fault;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;

    logic r_resp_valid;
    logic r_fault;
    logic r_from_mem;
    logic r_load_err;

    assign w_fetch_loc = word_loc(64'(fetch_addr_i), 64'(SEG_BASE), ADDR_W, DEPTH_WORDS, OFF_W);
    assign w_load_loc  = word_loc(64'(load_addr_i), 64'(SEG_BASE), ADDR_W, DEPTH_WORDS, OFF_W);
    assign w_fetch_idx = IDX_W'(w_fetch_loc.index);
    assign w_load_idx  = IDX_W'(w_load_loc.index);

    assign w_fault = !w_fetch_loc.in_range || ((fetch_addr_i & OFF_MASK) != '0);

    assign fetch_req_ready_o = rst_n && !load_wr_en_i && !fetch_flush_i
                               && (!r_resp_valid || fetch_resp_ready_i);
    assign w_accept = fetch_req_valid_i && fetch_req_ready_o;
    assign w_rd_en  = w_accept && !w_fault;
    assign w_wr_en  = load_wr_en_i && w_load_loc.in_range;

    instr_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_fetch_idx),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_load_idx),
        .i_wr_data (load_data_i),
        .i_wr_be   (load_be_i)
    );

    // The array's read register is the response data; it only changes on an accepted
    // in-range fetch, so stalls and loader writes leave the held response intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_from_mem   <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_load_err <= load_wr_en_i && !w_load_loc.in_range;
            if (fetch_flush_i) begin
                r_resp_valid <= 1'b0;
            end else if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_fault      <= w_fault;
                r_from_mem   <= !w_fault;
            end else if (fetch_resp_ready_i) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign fetch_resp_valid_o = r_resp_valid;
    assign fetch_fault_o      = r_fault;
    assign fetch_instr_o      = r_from_mem ? w_rd_data : NOP_WORD;
    assign load_err_o         = r_load_err;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed vector bench for instr_mem_fetch with default parameters (base 0x2000, 2048 words).
module tb_instr_mem_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, flush, resp_valid, resp_ready, fault;
    logic        ld_en, ld_err;
    logic [31:0] fetch_addr, instr, ld_addr, ld_data;
    logic [3:0]  ld_be;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic        ld;
        logic [31:0] la;
        logic [31:0] ldd;
        logic [3:0]  be;
        logic        rv;
        logic [31:0] fa;
        logic        fl;
        logic        rr;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_i;
        logic        e_f;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    instr_mem_fetch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_req_valid_i  (req_valid),
        .fetch_req_ready_o  (req_ready),
        .fetch_addr_i       (fetch_addr),
        .fetch_flush_i      (flush),
        .fetch_resp_valid_o (resp_valid),
        .fetch_resp_ready_i (resp_ready),
        .fetch_instr_o      (instr),
        .fetch_fault_o      (fault),
        .load_wr_en_i       (ld_en),
        .load_addr_i        (ld_addr),
        .load_data_i        (ld_data),
        .load_be_i          (ld_be),
        .load_err_o         (ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic ld, input logic [31:0] la, input logic [31:0] ldd,
                         input logic [3:0] be, input logic rv, input logic [31:0] fa,
                         input logic fl, input logic rr);
        ld_en = ld; ld_addr = la; ld_data = ldd; ld_be = be;
        req_valid = rv; fetch_addr = fa; flush = fl; resp_ready = rr;
    endtask

    // Checks ready mid-cycle, then the registered outputs 1ns after the edge.
    task automatic step_chk(input string tag, input logic e_rdy, input logic e_v,
                            input logic [31:0] e_i, input logic e_f, input logic e_err);
        #2;
        chk({tag, " ready"}, 32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 32'(resp_valid), 32'(e_v));
        chk({tag, " load_err"}, 32'(ld_err), 32'(e_err));
        if (e_v) begin
            chk({tag, " instr"}, instr, e_i);
            chk({tag, " fault"}, 32'(fault), 32'(e_f));
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [31:0] la, input logic [31:0] ldd,
                                input logic [3:0] be, input logic rv, input logic [31:0] fa,
                                input logic rr, input logic e_rdy, input logic e_v,
                                input logic [31:0] e_i, input logic e_f, input logic e_err);
        vec_t v;
        v.ld = ld; v.la = la; v.ldd = ldd; v.be = be; v.rv = rv; v.fa = fa; v.fl = 1'b0;
        v.rr = rr; v.e_rdy = e_rdy; v.e_v = e_v; v.e_i = e_i; v.e_f = e_f; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        //                ld  ld_addr      ld_data       be     rv  f_addr       rr  rdy v   instr         f  err
        vecs.push_back(mk(1, 32'h2000, 32'h0050_0093, 4'hF, 1, 32'h2000, 1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2000, 1, 1, 1, 32'h0050_0093, 0, 0));
        vecs.push_back(mk(1, 32'h2004, 32'h1111_1111, 4'hF, 0, 32'h0,    1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h2008, 32'h2222_2222, 4'hF, 0, 32'h0,    1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h3FFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0,    1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h6000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,    1, 0, 0, 32'h0,         0, 1));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 0, 32'h0,    1, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2000, 1, 1, 1, 32'h0050_0093, 0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2004, 1, 1, 1, 32'h1111_1111, 0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2008, 1, 1, 1, 32'h2222_2222, 0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h1FFC, 1, 1, 1, NOP,           1, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h4000, 1, 1, 1, NOP,           1, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2002, 1, 1, 1, NOP,           1, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h3FFC, 1, 1, 1, 32'hCAFE_F00D, 0, 0));
        vecs.push_back(mk(1, 32'h200C, 32'hAABB_CCDD, 4'hF, 0, 32'h0,    1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h200C, 32'h0000_1100, 4'h2, 0, 32'h0,    1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h200C, 1, 1, 1, 32'hAABB_11DD, 0, 0));
        vecs.push_back(mk(1, 32'h2010, 32'h1234_5678, 4'hF, 1, 32'h2010, 1, 0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2010, 0, 1, 1, 32'h1234_5678, 0, 0));
        vecs.push_back(mk(1, 32'h2010, 32'h0000_0000, 4'hF, 0, 32'h0,    0, 0, 1, 32'h1234_5678, 0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 0, 32'h0,    1, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,    32'h0,         4'h0, 1, 32'h2010, 1, 1, 1, 32'h0000_0000, 0, 0));

        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 0, 1);
        #12;
        chk("reset ready", 32'(req_ready), 32'h0);
        chk("reset valid", 32'(resp_valid), 32'h0);
        chk("reset instr", instr, NOP);
        chk("reset fault", 32'(fault), 32'h0);
        chk("reset load_err", 32'(ld_err), 32'h0);
        rst_n = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ld, vecs[i].la, vecs[i].ldd, vecs[i].be, vecs[i].rv, vecs[i].fa,
                  vecs[i].fl, vecs[i].rr);
            step_chk($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_v, vecs[i].e_i,
                     vecs[i].e_f, vecs[i].e_err);
        end

        // Back-to-back fetches with a three-cycle stall on the second response.
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 0, 1);
        step_chk("b2b first", 1, 1, 32'h0050_0093, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2004, 0, 1);
        step_chk("b2b second", 1, 1, 32'h1111_1111, 0, 0);
        for (int s = 0; s < 3; s++) begin
            drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2008, 0, 0);
            step_chk($sformatf("b2b stall%0d", s), 0, 1, 32'h1111_1111, 0, 0);
        end
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2008, 0, 1);
        step_chk("b2b third", 1, 1, 32'h2222_2222, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 1);
        step_chk("b2b drain", 1, 0, 32'h0, 0, 0);

        // Asynchronous reset while a response is stalled.
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2004, 0, 1);
        step_chk("rst pend", 1, 1, 32'h1111_1111, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        step_chk("rst stall", 0, 1, 32'h1111_1111, 0, 0);
        req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(resp_valid), 32'h0);
        chk("midrst instr", instr, NOP);
        chk("midrst ready", 32'(req_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 0, 1);
        step_chk("post rst fetch", 1, 1, 32'h0050_0093, 0, 0);

        // Flush during a stall, with and without resp_ready.
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        step_chk("flush hold", 0, 1, 32'h0050_0093, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2004, 1, 1);
        step_chk("flush rr1", 0, 0, 32'h0, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0);
        step_chk("flush after", 1, 0, 32'h0, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2008, 0, 0);
        step_chk("flush refetch", 1, 1, 32'h2222_2222, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 1, 32'h2000, 1, 0);
        step_chk("flush rr0", 0, 0, 32'h0, 0, 0);
        drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 1);
        step_chk("flush idle", 1, 0, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
